alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 106 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Operand, adder and result signals between alu_seq_ctrl and its producer, adder and consumer.
interface alu_seq_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       chain;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_c;
    logic       alu_over;
    logic [7:0] result;
    logic       ovf;
    logic       ovf_sticky;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] op_cnt;

    modport slave (
        input  in_valid, in_data, chain, alu_c, alu_over, res_ready,
        output in_ready, alu_a, alu_b, result, ovf, ovf_sticky, res_valid, op_cnt
    );

    modport master (
        output in_valid, in_data, chain, alu_c, alu_over, res_ready,
        input  in_ready, alu_a, alu_b, result, ovf, ovf_sticky, res_valid, op_cnt
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences two operand bytes into an external adder and captures sum/overflow; result valid two edges after B.
// Operand input stalls (in_ready=0) while a result is in flight; the result holds until res_ready.
module alu_seq_ctrl #(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    alu_seq_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {GET_A, GET_B, EXEC, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       sticky_q, sticky_d;
    logic       vld_q, vld_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GET_A;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            vld_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;

        // clear outranks any handshake on the same edge
        if (clear) begin
            state_d  = GET_A;
            a_d      = 8'h00;
            b_d      = 8'h00;
            result_d = 8'h00;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            vld_d    = 1'b0;
            cnt_d    = 8'h00;
        end else begin
            case (state_q)
                GET_A: if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = GET_B;
                end
                GET_B: if (bus.in_valid) begin
                    b_d     = bus.in_data;
                    state_d = EXEC;
                end
                EXEC: begin
                    result_d = bus.alu_c;
                    ovf_d    = bus.alu_over;
                    sticky_d = sticky_q | bus.alu_over;
                    vld_d    = 1'b1;
                    state_d  = HOLD;
                end
                HOLD: if (bus.res_ready) begin
                    vld_d = 1'b0;
                    cnt_d = cnt_q + 8'h01;
                    if (CHAIN_EN && bus.chain) begin
                        a_d     = result_q;
                        state_d = GET_B;
                    end else begin
                        state_d = GET_A;
                    end
                end
                default: state_d = GET_A;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == GET_A) || (state_q == GET_B);
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.res_valid  = vld_q;
    assign bus.op_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench: u0 chains (CHAIN_EN=1), u1 does not; both see identical stimulus and a signed-overflow adder.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       chain;
    logic       res_ready;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl_if i0 ();
    alu_seq_ctrl_if i1 ();

    assign i0.in_valid  = in_valid;
    assign i0.in_data   = in_data;
    assign i0.chain     = chain;
    assign i0.res_ready = res_ready;
    assign i0.alu_c     = i0.alu_a + i0.alu_b;
    assign i0.alu_over  = (i0.alu_a[7] == i0.alu_b[7]) && (i0.alu_c[7] != i0.alu_a[7]);

    assign i1.in_valid  = in_valid;
    assign i1.in_data   = in_data;
    assign i1.chain     = chain;
    assign i1.res_ready = res_ready;
    assign i1.alu_c     = i1.alu_a + i1.alu_b;
    assign i1.alu_over  = (i1.alu_a[7] == i1.alu_b[7]) && (i1.alu_c[7] != i1.alu_a[7]);

    alu_seq_ctrl #(.CHAIN_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(i0));
    alu_seq_ctrl #(.CHAIN_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got=timeout exp=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge where the DUT sits in EXEC.
    task automatic load(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk); in_valid = 1'b1; in_data = a;
        @(negedge clk); in_data = b;
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk); in_valid = 1'b1; in_data = d;
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic ack(input logic ch);
        res_ready = 1'b1; chain = ch;
        @(negedge clk); res_ready = 1'b0; chain = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        chain = 1'b0; res_ready = 1'b0;
        #2;
        chk("rst_in_ready", i0.in_ready, 1'b1);
        chk("rst_alu_a", i0.alu_a, 8'h00);
        chk("rst_result", i0.result, 8'h00);
        chk("rst_op_cnt", i0.op_cnt, 8'h00);
        chk("rst_res_valid", i0.res_valid, 1'b0);
        chk("rst_sticky", i0.ovf_sticky, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // 5 + 3
        load(8'h05, 8'h03);
        chk("exec_alu_a", i0.alu_a, 8'h05);
        chk("exec_alu_b", i0.alu_b, 8'h03);
        chk("exec_in_ready", i0.in_ready, 1'b0);
        chk("exec_res_valid", i0.res_valid, 1'b0);
        @(negedge clk);
        chk("add_res_valid", i0.res_valid, 1'b1);
        chk("add_result", i0.result, 8'h08);
        chk("add_ovf", i0.ovf, 1'b0);
        ack(1'b0);
        chk("add_res_valid_drop", i0.res_valid, 1'b0);
        chk("add_op_cnt", i0.op_cnt, 8'h01);
        chk("add_in_ready", i0.in_ready, 1'b1);

        // signed overflow, then a clean add with sticky retained
        load(8'h7F, 8'h01);
        @(negedge clk);
        chk("ovf_result", i0.result, 8'h80);
        chk("ovf_flag", i0.ovf, 1'b1);
        chk("ovf_sticky", i0.ovf_sticky, 1'b1);
        ack(1'b0);
        load(8'h01, 8'h01);
        @(negedge clk);
        chk("ovf2_result", i0.result, 8'h02);
        chk("ovf2_flag", i0.ovf, 1'b0);
        chk("ovf2_sticky", i0.ovf_sticky, 1'b1);
        ack(1'b0);
        chk("ovf2_op_cnt", i0.op_cnt, 8'h03);

        // res_ready outside HOLD is ignored
        @(negedge clk); res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        chk("idle_ack_op_cnt", i0.op_cnt, 8'h03);
        chk("idle_ack_in_ready", i0.in_ready, 1'b1);

        // stall in HOLD with in_valid toggling
        load(8'h11, 8'h22);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = ~in_valid; in_data = 8'hEE;
            chk("hold_in_ready", i0.in_ready, 1'b0);
            chk("hold_result", i0.result, 8'h33);
            chk("hold_ovf", i0.ovf, 1'b0);
            chk("hold_res_valid", i0.res_valid, 1'b1);
            chk("hold_alu_a", i0.alu_a, 8'h11);
            chk("hold_alu_b", i0.alu_b, 8'h22);
        end
        in_valid = 1'b0;
        ack(1'b0);
        chk("hold_op_cnt", i0.op_cnt, 8'h04);

        do_clear();
        chk("clr_sticky", i0.ovf_sticky, 1'b0);
        chk("clr_op_cnt", i0.op_cnt, 8'h00);
        chk("clr_result", i0.result, 8'h00);
        chk("clr_alu_a", i0.alu_a, 8'h00);

        // chaining: u0 reuses 0x30 as A, u1 returns to GET_A
        load(8'h10, 8'h20);
        @(negedge clk);
        chk("chain1_result", i0.result, 8'h30);
        ack(1'b1);
        chk("chain_u0_in_ready", i0.in_ready, 1'b1);
        chk("chain_u0_alu_a", i0.alu_a, 8'h30);
        chk("chain_u1_alu_a", i1.alu_a, 8'h10);
        chk("chain_u1_op_cnt", i1.op_cnt, 8'h01);
        push(8'h05);
        chk("chain_u0_alu_b", i0.alu_b, 8'h05);
        chk("chain_u0_exec", i0.in_ready, 1'b0);
        chk("chain_u1_alu_a2", i1.alu_a, 8'h05);
        chk("chain_u1_in_ready", i1.in_ready, 1'b1);
        @(negedge clk);
        chk("chain2_result", i0.result, 8'h35);
        ack(1'b0);
        chk("chain2_op_cnt", i0.op_cnt, 8'h02);

        // clear during EXEC discards the capture
        load(8'h40, 8'h50);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("clrx_in_ready", i0.in_ready, 1'b1);
        chk("clrx_res_valid", i0.res_valid, 1'b0);
        chk("clrx_result", i0.result, 8'h00);
        chk("clrx_alu_a", i0.alu_a, 8'h00);
        chk("clrx_alu_b", i0.alu_b, 8'h00);
        chk("clrx_op_cnt", i0.op_cnt, 8'h00);
        @(negedge clk);
        chk("clrx_no_capture", i0.res_valid, 1'b0);

        // clear together with a HOLD handshake
        load(8'h01, 8'h02);
        @(negedge clk);
        chk("clrh_result_pre", i0.result, 8'h03);
        res_ready = 1'b1; clear = 1'b1;
        @(negedge clk); res_ready = 1'b0; clear = 1'b0;
        chk("clrh_op_cnt", i0.op_cnt, 8'h00);
        chk("clrh_res_valid", i0.res_valid, 1'b0);
        chk("clrh_result", i0.result, 8'h00);
        chk("clrh_in_ready", i0.in_ready, 1'b1);

        // async reset in GET_B, then immediate accept
        push(8'h09);
        chk("rstp_pre_alu_a", i0.alu_a, 8'h09);
        #1 rst_n = 1'b0;
        #1;
        chk("rstp_in_ready", i0.in_ready, 1'b1);
        chk("rstp_alu_a", i0.alu_a, 8'h00);
        #1 rst_n = 1'b1;
        push(8'h0A);
        chk("rstp_accept_alu_a", i0.alu_a, 8'h0A);
        chk("rstp_accept_in_ready", i0.in_ready, 1'b1);
        do_clear();

        // 256 operations wrap op_cnt
        for (int n = 0; n < 256; n++) begin
            logic [7:0] av;
            av = n[7:0];
            load(av, 8'h03);
            @(negedge clk);
            chk("wrap_result", i0.result, {24'h0, av + 8'h03});
            ack(1'b0);
            if (n == 254) chk("wrap_op_cnt_ff", i0.op_cnt, 8'hFF);
        end
        chk("wrap_op_cnt_00", i0.op_cnt, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
